maquina_estados_param: RTL and testbench
========================================

// Module: maquina_estados_param
// PURPOSE
//  Parametrised successor of the flow-control state machine: supervises NUM_FIFOS FIFOs through RESET/INIT/IDLE/ACTIVE/ERROR.
//  Latches and validates low/high thresholds during INIT and filters ACTIVE->IDLE with a hold counter.
//  Traps per-FIFO error flags into a sticky ERROR state.
//  Sits beside the FIFO bank; its threshold outputs feed the FIFOs' almost-empty/almost-full logic.
// PARAMETERS
//  NUM_FIFOS  8  number of supervised FIFOs (>=2)
//  UMBRAL_W   3  threshold width, bits
//  IDLE_HOLD  4  consecutive all-empty cycles required for ACTIVE->IDLE (>=1)
// PORTS
//  clk          in   1                   clock, rising edge
//  reset        in   1                   asynchronous, active-low reset
//  init         in   1                   1 = enter/stay in INIT and load thresholds
//  bajo         in   UMBRAL_W            low threshold candidate
//  alto         in   UMBRAL_W            high threshold candidate
//  empty_fifos  in   NUM_FIFOS           bit i = FIFO i empty
//  error_fifos  in   NUM_FIFOS           bit i = FIFO i overflow/underflow this cycle
//  estado       out  3                   registered state: RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4
//  sig_estado   out  3                   combinational next state
//  bajo_out     out  UMBRAL_W            registered low threshold in use
//  alto_out     out  UMBRAL_W            registered high threshold in use
//  idle_out     out  1                   registered, 1 while estado==IDLE
//  active_out   out  1                   registered, 1 while estado==ACTIVE
//  error_out    out  1                   registered, 1 while estado==ERROR (sticky)
//  cfg_err_out  out  1                   registered, 1 while in INIT with bajo>=alto
//  error_id     out  $clog2(NUM_FIFOS)   registered index of the lowest failing FIFO
// BEHAVIOUR
//  - reset==0 (async): estado=RESET; all registered outputs 0; hold counter 0.
//  - RESET: on the first clk edge with reset==1, go to INIT.
//  - INIT:
//      - each cycle with bajo<alto: bajo_out<=bajo, alto_out<=alto, cfg_err_out<=0.
//      - bajo>=alto: thresholds keep their old values and cfg_err_out<=1.
//      - exit to IDLE only when init==0 and bajo<alto; otherwise stay in INIT.
//  - IDLE: any empty_fifos bit 0 -> ACTIVE next cycle.
//  - ACTIVE:
//      - hold counter increments while empty_fifos is all 1s and clears otherwise.
//      - with the counter at IDLE_HOLD-1 and all empty, go to IDLE. Total latency is IDLE_HOLD cycles.
//      - the counter saturates and clears on leaving ACTIVE.
//  - init==1 in IDLE or ACTIVE -> INIT next cycle. Thresholds stay until revalidated.
//  - ERROR:
//      - entered from INIT, IDLE or ACTIVE when any error_fifos bit is 1.
//      - error_id captures the lowest set index on entry.
//      - the only exit is reset==0. init and empty_fifos are ignored.
//  - Priority on simultaneous events: error_fifos > init > empty-based transitions.
//  - Outputs are Moore, decoded into registers with the state. They are valid in the same cycle estado changes.
//  - sig_estado reflects current inputs combinationally and equals the next estado.
//  - reset asserted mid-operation: immediate return to RESET with all outputs 0. Thresholds are lost.
//  - Threshold compare is unsigned over UMBRAL_W bits. No clamping or wrap.
// TESTING
//  1. reset=0 for 2 clk, then 1 with init=1, bajo=2, alto=5.
//     -> estado 0 then 1; bajo_out=2, alto_out=5.
//     Then init=0 -> estado=2, idle_out=1.
//  2. INIT with bajo=6, alto=3, init=0 -> stays in INIT, cfg_err_out=1, thresholds unchanged.
//     Then bajo=1 -> IDLE next cycle.
//  3. IDLE, empty_fifos=8'hFE for 1 cycle -> ACTIVE, active_out=1.
//     empty_fifos=8'hFF for 3 cycles -> still ACTIVE.
//     4th all-empty cycle -> IDLE (IDLE_HOLD=4).
//  4. ACTIVE, empty pattern toggles 8'hFF,8'hFF,8'h7F,8'hFF x4 -> counter restarts; IDLE only after the final 4 all-empty cycles.
//  5. ACTIVE, error_fifos=8'h24 and init=1 in the same cycle -> ERROR, error_out=1, error_id=2.
//     Then init/empty toggles -> stays in ERROR until reset=0.
//  6. Async reset=0 between edges while ACTIVE -> estado=0 and all outputs 0 without a clk edge.
//     Rerun with NUM_FIFOS=4, UMBRAL_W=4, IDLE_HOLD=1.

Source files
------------

// File: rtl/maquina_estados_param.sv
// Flow-control supervisor for a bank of NUM_FIFOS FIFOs: RESET/INIT/IDLE/ACTIVE/ERROR.
// Latency: state and decoded outputs registered one cycle after inputs; sig_estado is combinational.
// Backpressure: none; error_fifos traps into a sticky ERROR that only the async reset clears.
module maquina_estados_param #(
  parameter int NUM_FIFOS = 8,
  parameter int UMBRAL_W  = 3,
  parameter int IDLE_HOLD = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic [UMBRAL_W-1:0]          bajo,
  input  logic [UMBRAL_W-1:0]          alto,
  input  logic [NUM_FIFOS-1:0]         empty_fifos,
  input  logic [NUM_FIFOS-1:0]         error_fifos,
  output logic [2:0]                   estado,
  output logic [2:0]                   sig_estado,
  output logic [UMBRAL_W-1:0]          bajo_out,
  output logic [UMBRAL_W-1:0]          alto_out,
  output logic                         idle_out,
  output logic                         active_out,
  output logic                         error_out,
  output logic                         cfg_err_out,
  output logic [$clog2(NUM_FIFOS)-1:0] error_id
);

  localparam int ID_W = $clog2(NUM_FIFOS);
  localparam int CW   = (IDLE_HOLD > 1) ? $clog2(IDLE_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(IDLE_HOLD - 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [ID_W-1:0] low_id;
  logic            all_empty;
  logic            any_err;
  logic            thr_ok;

  assign all_empty = &empty_fifos;
  assign any_err   = |error_fifos;
  assign thr_ok    = (bajo < alto);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    low_id = '0;
    for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
      if (error_fifos[i]) low_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT: begin
        if (any_err)              state_d = S_ERROR;
        else if (!init && thr_ok) state_d = S_IDLE;
        else                      state_d = S_INIT;
      end
      S_IDLE: begin
        if (any_err)         state_d = S_ERROR;
        else if (init)       state_d = S_INIT;
        else if (!all_empty) state_d = S_ACTIVE;
        else                 state_d = S_IDLE;
      end
      S_ACTIVE: begin
        if (any_err)                              state_d = S_ERROR;
        else if (init)                            state_d = S_INIT;
        else if (all_empty && cnt_q == HOLD_LAST) state_d = S_IDLE;
        else                                      state_d = S_ACTIVE;
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase
    // While reset is held the register cannot advance, so the true next state is RESET.
    if (!reset) state_d = S_RESET;
  end

  // Hold counter only survives consecutive all-empty cycles that remain in ACTIVE.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_ACTIVE && state_d == S_ACTIVE && all_empty) begin
      cnt_d = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bajo_out    <= '0;
      alto_out    <= '0;
      idle_out    <= 1'b0;
      active_out  <= 1'b0;
      error_out   <= 1'b0;
      cfg_err_out <= 1'b0;
      error_id    <= '0;
    end else begin
      idle_out    <= (state_d == S_IDLE);
      active_out  <= (state_d == S_ACTIVE);
      error_out   <= (state_d == S_ERROR);
      cfg_err_out <= (state_q == S_INIT) && (state_d == S_INIT) && !thr_ok;
      if (state_q == S_INIT && thr_ok) begin
        bajo_out <= bajo;
        alto_out <= alto;
      end
      if (state_q != S_ERROR && state_d == S_ERROR) error_id <= low_id;
    end
  end

  assign estado     = state_q;
  assign sig_estado = state_d;

endmodule

// File: tb/tb_maquina_estados_param.sv
// Bench for maquina_estados_param: two parameterisations driven in lockstep against a reference model.
module tb_maquina_estados_param;

  localparam int NFA = 8, UWA = 3, HA = 4;
  localparam int NFB = 4, UWB = 4, HB = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic init = 1'b1;
  logic [UWA-1:0] bajo_a = 3'd2, alto_a = 3'd5;
  logic [UWB-1:0] bajo_b = 4'd2, alto_b = 4'd5;
  logic [NFA-1:0] empty_a = '1, err_a = '0;
  logic [NFB-1:0] empty_b = '1, err_b = '0;

  logic [2:0] estado_a, sig_a, estado_b, sig_b;
  logic [UWA-1:0] bo_a, ao_a;
  logic [UWB-1:0] bo_b, ao_b;
  logic idle_a, act_a, er_a, cfg_a, idle_b, act_b, er_b, cfg_b;
  logic [2:0] eid_a;
  logic [1:0] eid_b;

  maquina_estados_param #(.NUM_FIFOS(NFA), .UMBRAL_W(UWA), .IDLE_HOLD(HA)) dut_a (
    .clk(clk), .reset(reset), .init(init), .bajo(bajo_a), .alto(alto_a),
    .empty_fifos(empty_a), .error_fifos(err_a), .estado(estado_a), .sig_estado(sig_a),
    .bajo_out(bo_a), .alto_out(ao_a), .idle_out(idle_a), .active_out(act_a),
    .error_out(er_a), .cfg_err_out(cfg_a), .error_id(eid_a));

  maquina_estados_param #(.NUM_FIFOS(NFB), .UMBRAL_W(UWB), .IDLE_HOLD(HB)) dut_b (
    .clk(clk), .reset(reset), .init(init), .bajo(bajo_b), .alto(alto_b),
    .empty_fifos(empty_b), .error_fifos(err_b), .estado(estado_b), .sig_estado(sig_b),
    .bajo_out(bo_b), .alto_out(ao_b), .idle_out(idle_b), .active_out(act_b),
    .error_out(er_b), .cfg_err_out(cfg_b), .error_id(eid_b));

  always #5 clk = ~clk;

  // Abstract model: mode number, thresholds in use, run length of all-empty ACTIVE cycles.
  typedef struct { int st; int bl; int al; int cfg; int streak; int eid; } mdl_t;
  typedef struct { int st; int sig; int bl; int al; int idl; int act; int er; int cfg; int eid; } exp_t;

  mdl_t ma, mb;
  exp_t qa[$], qb[$];
  int total = 0;
  int bad = 0;

  function automatic mdl_t mdl_next(input mdl_t m, input int nf, input int hold, input bit ini,
                                    input int b, input int a, input int emp, input int err);
    mdl_t n;
    int mask;
    bit alle, anye;
    int i;
    n = m;
    mask = (1 << nf) - 1;
    alle = ((emp & mask) == mask);
    anye = ((err & mask) != 0);
    case (m.st)
      0: n.st = 1;
      1: begin
        if (anye) n.st = 4;
        else if (!ini && b < a) n.st = 2;
        else n.st = 1;
        if (b < a) begin n.bl = b; n.al = a; end
      end
      2: n.st = anye ? 4 : ini ? 1 : !alle ? 3 : 2;
      3: n.st = anye ? 4 : ini ? 1 : (alle && m.streak + 1 >= hold) ? 2 : 3;
      default: n.st = 4;
    endcase
    n.cfg = (m.st == 1 && n.st == 1 && b >= a) ? 1 : 0;
    n.streak = (m.st == 3 && n.st == 3 && alle) ? m.streak + 1 : 0;
    if (m.st != 4 && n.st == 4) begin
      i = 0;
      while (i < nf && !err[i]) i++;
      n.eid = i;
    end
    return n;
  endfunction

  function automatic exp_t mk(input mdl_t m, input int sig);
    exp_t e;
    e.st = m.st; e.sig = sig; e.bl = m.bl; e.al = m.al;
    e.idl = (m.st == 2); e.act = (m.st == 3); e.er = (m.st == 4);
    e.cfg = m.cfg; e.eid = m.eid;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit ini, input int b, input int a, input int emp, input int err);
    mdl_t na, nb;
    @(posedge clk);
    #1;
    reset = rst; init = ini;
    bajo_a = b[2:0]; alto_a = a[2:0]; bajo_b = b[3:0]; alto_b = a[3:0];
    empty_a = emp[7:0]; err_a = err[7:0]; empty_b = emp[3:0]; err_b = err[3:0];
    if (!rst) begin
      ma = '{default: 0};
      mb = '{default: 0};
      na = ma;
      nb = mb;
    end else begin
      na = mdl_next(ma, NFA, HA, ini, b & 7, a & 7, emp, err);
      nb = mdl_next(mb, NFB, HB, ini, b & 15, a & 15, emp, err);
    end
    qa.push_back(mk(ma, na.st));
    qb.push_back(mk(mb, nb.st));
    ma = na;
    mb = nb;
  endtask

  // Monitor: compares whatever expectations are pending at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a.estado", int'(estado_a), e.st);  chk("a.sig_estado", int'(sig_a), e.sig);
        chk("a.bajo_out", int'(bo_a), e.bl);    chk("a.alto_out", int'(ao_a), e.al);
        chk("a.idle_out", int'(idle_a), e.idl); chk("a.active_out", int'(act_a), e.act);
        chk("a.error_out", int'(er_a), e.er);   chk("a.cfg_err_out", int'(cfg_a), e.cfg);
        chk("a.error_id", int'(eid_a), e.eid);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b.estado", int'(estado_b), e.st);  chk("b.sig_estado", int'(sig_b), e.sig);
        chk("b.bajo_out", int'(bo_b), e.bl);    chk("b.alto_out", int'(ao_b), e.al);
        chk("b.idle_out", int'(idle_b), e.idl); chk("b.active_out", int'(act_b), e.act);
        chk("b.error_out", int'(er_b), e.er);   chk("b.cfg_err_out", int'(cfg_b), e.cfg);
        chk("b.error_id", int'(eid_b), e.eid);
      end
    end
  end

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    // Reset, threshold load, exit to IDLE
    step(0, 1, 2, 5, 'hFF, 0); step(0, 1, 2, 5, 'hFF, 0);
    step(1, 1, 2, 5, 'hFF, 0); step(1, 1, 2, 5, 'hFF, 0);
    step(1, 0, 2, 5, 'hFF, 0); step(1, 0, 2, 5, 'hFF, 0);
    // Invalid thresholds hold INIT and raise cfg_err
    step(1, 1, 2, 5, 'hFF, 0);
    step(1, 0, 6, 3, 'hFF, 0); step(1, 0, 6, 3, 'hFF, 0); step(1, 0, 6, 3, 'hFF, 0);
    step(1, 0, 1, 3, 'hFF, 0); step(1, 0, 1, 3, 'hFF, 0);
    // ACTIVE and hold filter
    step(1, 0, 1, 3, 'hFE, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 3, 'hFF, 0);
    // Interrupted all-empty run restarts the hold count
    step(1, 0, 1, 3, 'hFE, 0);
    step(1, 0, 1, 3, 'hFF, 0); step(1, 0, 1, 3, 'hFF, 0); step(1, 0, 1, 3, 'h7F, 0);
    step(1, 0, 1, 3, 'hFF, 0); step(1, 0, 1, 3, 'hFF, 0); step(1, 0, 1, 3, 'hFF, 0);
    step(1, 0, 1, 3, 'h7F, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 3, 'hFF, 0);
    // Error beats init; ERROR is sticky
    step(1, 0, 1, 3, 'hFE, 0);
    step(1, 1, 1, 3, 'hFE, 'h24);
    for (int i = 0; i < 6; i++) step(1, i % 2, 1, 3, (i % 3 == 0) ? 'h0F : 'hFF, 0);
    // Async reset mid-cycle while ACTIVE
    step(0, 1, 2, 5, 'hFF, 0);
    step(1, 1, 2, 5, 'hFF, 0); step(1, 0, 2, 5, 'hFF, 0); step(1, 0, 2, 5, 'hFF, 0);
    step(1, 0, 2, 5, 'h00, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async.estado", int'(estado_a), 0);
    chk("async.active_out", int'(act_a), 0);
    chk("async.bajo_out", int'(bo_a), 0);
    chk("async.b_estado", int'(estado_b), 0);
    ma = '{default: 0};
    mb = '{default: 0};
    step(0, 1, 2, 5, 'hFF, 0);
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 60) != 0, ($urandom % 8) == 0, int'($urandom % 16), int'($urandom % 16),
           (($urandom % 3) == 0) ? int'($urandom % 256) : 'hFF,
           (($urandom % 50) == 0) ? int'($urandom % 255 + 1) : 0);
    end
    repeat (3) @(posedge clk);
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
